// File: rtl/seg_velocity_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : seg_velocity_gen_if
// Description : Segment command handshake between host and velocity generator.
// Revision    : 1.0
// ============================================================================
interface seg_velocity_gen_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_set_vel;
    logic [31:0] cmd_velocity;
    logic [31:0] cmd_accel;
    logic [31:0] cmd_duration;

    modport master (
        output cmd_valid,
        output cmd_set_vel,
        output cmd_velocity,
        output cmd_accel,
        output cmd_duration,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_set_vel,
        input  cmd_velocity,
        input  cmd_accel,
        input  cmd_duration,
        output cmd_ready
    );
endinterface
`default_nettype wire

// File: rtl/seg_velocity_gen.sv
`default_nettype none
// ============================================================================
// Module      : seg_velocity_gen
// Description : Segment-based velocity profile generator with a one-entry
//               command holding register. Define VELOCITY_CLAMP_EN to clamp
//               every velocity result to [-VMAX, +VMAX].
// Revision    : 1.0
// ============================================================================
module seg_velocity_gen #(
    parameter int          TICK_DIV = 100,
    parameter logic [31:0] VMAX     = 32'h3FFFFFFF
) (
    input  wire logic        clk,
    input  wire logic        reset,
    seg_velocity_gen_if.slave cmd,
    input  wire logic        abort,
    output logic [31:0]      velocity,
    output logic             busy,
    output logic             seg_done,
    output logic             underrun,
    output logic [31:0]      seg_remaining
);

    localparam logic [31:0] c_reload = 32'(TICK_DIV - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    if (TICK_DIV < 2 || VMAX[31]) begin : g_param_check
        $error("seg_velocity_gen: TICK_DIV must be >= 2 and VMAX positive");
    end

    state_t      r_state,         w_state_next;
    logic        r_pending,       w_pending_next;
    logic        r_hold_set_vel,  w_hold_set_vel_next;
    logic [31:0] r_hold_velocity, w_hold_velocity_next;
    logic [31:0] r_hold_accel,    w_hold_accel_next;
    logic [31:0] r_hold_duration, w_hold_duration_next;
    logic [31:0] r_accel,         w_accel_next;
    logic [31:0] r_velocity,      w_velocity_next;
    logic [31:0] r_remaining,     w_remaining_next;
    logic [31:0] r_prescaler,     w_prescaler_next;
    logic        r_seg_done,      w_seg_done_next;
    logic        r_underrun,      w_underrun_next;

    logic        w_accept;
    logic        w_load;
    logic [31:0] w_load_vel;
    logic [31:0] w_tick_vel;

    function automatic logic [31:0] f_sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {a[31], a} + {b[31], b};
        if (s[32] != s[31])
            return s[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        return s[31:0];
    endfunction

    function automatic logic [31:0] f_limit(input logic [31:0] v);
`ifdef VELOCITY_CLAMP_EN
        if ($signed(v) > $signed(VMAX))
            return VMAX;
        if ($signed(v) < -$signed(VMAX))
            return -VMAX;
        return v;
`else
        return v;
`endif
    endfunction

    assign w_accept      = cmd.cmd_valid && !r_pending && !abort;
    assign w_tick_vel    = f_limit(f_sat_add(r_velocity, r_accel));
    assign cmd.cmd_ready = !r_pending && !abort;
    assign velocity      = r_velocity;
    assign busy          = (r_state == ST_RUN) || r_pending;
    assign seg_done      = r_seg_done;
    assign underrun      = r_underrun;
    assign seg_remaining = r_remaining;

    always_comb begin
        w_state_next         = r_state;
        w_pending_next       = r_pending;
        w_hold_set_vel_next  = r_hold_set_vel;
        w_hold_velocity_next = r_hold_velocity;
        w_hold_accel_next    = r_hold_accel;
        w_hold_duration_next = r_hold_duration;
        w_accel_next         = r_accel;
        w_velocity_next      = r_velocity;
        w_remaining_next     = r_remaining;
        w_prescaler_next     = r_prescaler;
        w_seg_done_next      = 1'b0;
        w_underrun_next      = r_underrun;
        w_load               = 1'b0;
        w_load_vel           = r_velocity;

        if (abort) begin
            w_state_next     = ST_IDLE;
            w_pending_next   = 1'b0;
            w_velocity_next  = 32'd0;
            w_remaining_next = 32'd0;
            w_prescaler_next = c_reload;
            w_underrun_next  = 1'b0;
        end else begin
            if (w_accept) begin
                w_pending_next       = 1'b1;
                w_hold_set_vel_next  = cmd.cmd_set_vel;
                w_hold_velocity_next = cmd.cmd_velocity;
                w_hold_accel_next    = cmd.cmd_accel;
                w_hold_duration_next = cmd.cmd_duration;
            end

            case (r_state)
                ST_IDLE: w_load = r_pending;
                ST_RUN: begin
                    if (r_prescaler == 32'd0) begin
                        w_velocity_next  = w_tick_vel;
                        w_remaining_next = r_remaining - 32'd1;
                        w_prescaler_next = c_reload;
                        if (r_remaining == 32'd1) begin
                            w_seg_done_next = 1'b1;
                            if (r_pending) begin
                                w_load = 1'b1;
                            end else begin
                                w_state_next = ST_IDLE;
                                if (w_tick_vel != 32'd0)
                                    w_underrun_next = 1'b1;
                            end
                        end
                    end else begin
                        w_prescaler_next = r_prescaler - 32'd1;
                    end
                end
                default: w_state_next = ST_IDLE;
            endcase

            // A load on the final tick edge lets set_vel override that tick's add.
            if (w_load) begin
                w_load_vel       = r_hold_set_vel ? f_limit(r_hold_velocity) : w_velocity_next;
                w_velocity_next  = w_load_vel;
                w_pending_next   = 1'b0;
                w_accel_next     = r_hold_accel;
                w_remaining_next = r_hold_duration;
                w_prescaler_next = c_reload;
                w_state_next     = ST_RUN;
                if (r_hold_duration == 32'd0) begin
                    w_seg_done_next = 1'b1;
                    w_state_next    = ST_IDLE;
                    if (w_load_vel != 32'd0)
                        w_underrun_next = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= ST_IDLE;
            r_pending       <= 1'b0;
            r_hold_set_vel  <= 1'b0;
            r_hold_velocity <= 32'd0;
            r_hold_accel    <= 32'd0;
            r_hold_duration <= 32'd0;
            r_accel         <= 32'd0;
            r_velocity      <= 32'd0;
            r_remaining     <= 32'd0;
            r_prescaler     <= c_reload;
            r_seg_done      <= 1'b0;
            r_underrun      <= 1'b0;
        end else begin
            r_state         <= w_state_next;
            r_pending       <= w_pending_next;
            r_hold_set_vel  <= w_hold_set_vel_next;
            r_hold_velocity <= w_hold_velocity_next;
            r_hold_accel    <= w_hold_accel_next;
            r_hold_duration <= w_hold_duration_next;
            r_accel         <= w_accel_next;
            r_velocity      <= w_velocity_next;
            r_remaining     <= w_remaining_next;
            r_prescaler     <= w_prescaler_next;
            r_seg_done      <= w_seg_done_next;
            r_underrun      <= w_underrun_next;
        end
    end

endmodule
`default_nettype wire

// File: doc/seg_velocity_gen.md
Name: seg_velocity_gen

Overview:
Segment-based velocity profile generator that drives the signed 32-bit velocity input of the step generator. It accepts motion segments (optional initial velocity, constant acceleration, duration in ticks) through a valid/ready handshake into a one-entry holding register. It executes them back-to-back with no gap, integrating acceleration into velocity once per prescaled tick. It sits between the host command path and one step generator axis.

Parameters:
TICK_DIV, 100, clocks per velocity update tick (>=2)
VMAX, 32'h3FFFFFFF, velocity magnitude limit used only when VELOCITY_CLAMP_EN is defined

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
cmd_valid  in  1  segment command valid
cmd_ready  out  1  holding register empty; command accepted when cmd_valid && cmd_ready
cmd_set_vel  in  1  load cmd_velocity at segment start
cmd_velocity  in  32  signed start velocity
cmd_accel  in  32  signed per-tick velocity increment
cmd_duration  in  32  unsigned segment length in ticks
abort  in  1  emergency stop
velocity  out  32  signed velocity to step generator
busy  out  1  RUN state or holding register full
seg_done  out  1  one-cycle pulse at segment completion
underrun  out  1  sticky: segment ended, queue empty, velocity nonzero
seg_remaining  out  32  ticks left in the active segment

Behaviour:
- Reset: velocity=0, cmd_ready=1, busy=0, seg_done=0, underrun=0, seg_remaining=0, holding register empty, state IDLE, prescaler=TICK_DIV-1.
- Holding register: captures the command on the accept edge. cmd_ready = !pending && !abort.
- States: IDLE, RUN.
- IDLE with pending: on the next edge, move the command to the active segment, clear pending, and go to RUN. Set velocity to cmd_velocity if set_vel. Load seg_remaining=duration and prescaler=TICK_DIV-1.
- Load timing: accept at edge N gives load at edge N+1. The first tick is at edge N+1+TICK_DIV, and later ticks are every TICK_DIV clocks.
- RUN tick (prescaler==0): velocity += accel (saturating), seg_remaining -= 1, prescaler reloads TICK_DIV-1. Otherwise the prescaler decrements.
- Segment end occurs on the tick edge where seg_remaining becomes 0. seg_done=1 for the following cycle.
- If pending at segment end: load the next segment on the same edge as the final tick. The new segment's set_vel overrides the final accel add. No idle cycle.
- If not pending at segment end: go to IDLE and hold velocity. If velocity != 0, set underrun.
- duration=0: the segment completes on its load edge. Only set_vel is applied, seg_done pulses next cycle, and the underrun rule applies.
- Arithmetic: 33-bit add, saturate to 32'h7FFFFFFF / 32'h80000000. No wrap ever.
- abort (any state, highest priority below reset): next edge velocity=0, state IDLE, pending cleared, underrun cleared, seg_remaining=0, no seg_done. A cmd_valid in the same cycle is not accepted.
- Reset mid-segment behaves identically to power-on reset.
- Outputs are registered; velocity changes only on load, tick or abort edges.

Optional Feature:
VELOCITY_CLAMP_EN
- Defined: every velocity result (set_vel load and tick add) is clamped to [-VMAX, +VMAX] after saturation.
- Undefined: only full-range 32-bit saturation applies, and VMAX is unused.

Test Plan:
1. Assert reset 3 cycles -> velocity=0, cmd_ready=1, busy=0, underrun=0, seg_done=0.
2. TICK_DIV=4; accept {set_vel=0, accel=10, duration=3} at edge N -> velocity 10/20/30 at edges N+5/N+9/N+13. seg_done high one cycle after N+13, busy low, underrun=1.
3. Queue {accel=+10, dur=2} then {accel=-10, dur=2} while the first runs -> velocity 10,20,10,0 at evenly spaced ticks, no gap. Two seg_done pulses, underrun stays 0.
4. {set_vel=1, velocity=-5, duration=0} -> velocity=-5 one edge after accept+1, seg_done pulse, underrun=1. Then abort -> velocity=0, underrun=0.
5. {set_vel=1, velocity=32'h7FFFFFF0, accel=32'h100, dur=1} -> velocity 32'h7FFFFFFF (macro off). With VELOCITY_CLAMP_EN and VMAX=1000: velocity=1000 from the load edge.
6. abort asserted mid-RUN with pending full and cmd_valid high -> next edge velocity=0, busy=0, cmd not accepted, no seg_done. The next command after abort deasserts executes normally.
